sdram_main_arb: RTL and testbench
=================================

# sdram_main_arb

Parametrised SDRAM main controller and arbiter: the next generation of the single-channel init/refresh/write control block. It sequences power-up init, then grants the command bus to the refresh, write or read engine. Refresh always wins; writes and reads share round-robin fairness. It owns the command mux and the tristate DQ bus, and sits between the sub-engines (`sdram_init`, `sdram_ref`, `sdram_write`, `sdram_read`) and the SDRAM pins.

## Interface
- `DQ_W`, 16: SDRAM data width.
- `BA_W`, 2: bank address width.
- `ADDR_W`, 12: row/column address width.
- `CMD_W`, 4+BA_W+ADDR_W: command word, `{cs_n,ras_n,cas_n,we_n,ba,addr}`.
- `WDOG_CYC`, 1024: maximum cycles allowed in REF/WRITE/READ (used only with the watchdog).

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous active-high reset.
- `init_end` in 1: init engine done, level.
- `init_cmd` in CMD_W: init engine command.
- `ref_req` in 1: refresh request, level.
- `ref_en` out 1: refresh grant pulse.
- `ref_end` in 1: refresh done pulse.
- `ref_cmd` in CMD_W: refresh command.
- `w_req` in 1: write request, level.
- `w_en` out 1: write grant pulse.
- `w_end`, `w_brk_end` in 1: write finished / write aborted for refresh.
- `w_cmd` in CMD_W: write command.
- `w_dq` in DQ_W: write data.
- `r_req` in 1: read request, level.
- `r_en` out 1: read grant pulse.
- `r_end`, `r_brk_end` in 1: read finished / read aborted for refresh.
- `r_cmd` in CMD_W: read command.
- `r_dq` out DQ_W: DQ sampled input, unregistered.
- `cmd` out CMD_W: SDRAM command.
- `dq` inout DQ_W: SDRAM data bus.
- `state` out 6: current state, one-hot.
- `wdog_err` out 1: sticky watchdog error.

## Operation
- States are one-hot: IDLE=000001, INI=000010, SW=000100, REF=001000, WRITE=010000, READ=100000.
- IDLE→INI: unconditional, 1 cycle after reset release.
- INI→SW: when `init_end`=1.
- In SW, the following rules apply:
  - `ref_req` takes REF.
  - Otherwise, if exactly one of `w_req`/`r_req` is asserted, that one wins.
  - If both are asserted, the winner is the one opposite to `last_wr`.
  - `last_wr` is a register, reset 0, so the first contested grant goes to WRITE. It updates on every WRITE/READ grant.
- REF→SW on `ref_end`. WRITE→SW on `w_end|w_brk_end`. READ→SW on `r_end|r_brk_end`.
- End pulses arriving in any other state are ignored.
- `ref_en`/`w_en`/`r_en` are combinational: high only in SW in the cycle the transition is taken. They are mutually exclusive and 1 cycle wide.
- `cmd` is a mux on state:
  - INI selects `init_cmd`; REF selects `ref_cmd`; WRITE selects `w_cmd`; READ selects `r_cmd`.
  - IDLE/SW drive NOP: `{4'b0111, zeros}`.
- `dq` is driven with `w_dq` only in WRITE; otherwise it is high-Z. `r_dq` = `dq` always.

## Timing
- Reset values:
  - `state`=IDLE, `last_wr`=0, `wdog_err`=0.
  - `cmd`=NOP, `dq`=Z.
  - All `*_en`=0.
- Grant latency: a request seen in SW produces `*_en` in the same cycle, and the new state appears on the next edge. The engine's first command appears in that next cycle.
- Minimum SW dwell is 1 cycle between operations. An end pulse returns to SW on the next edge.
- Simultaneous `ref_req`+`w_req`+`r_req`: REF is granted; `last_wr` is unchanged.
- Reset mid-operation: async return to IDLE. DQ is released to Z immediately (combinational on state), and `cmd` is NOP.

## Configuration
- `SDRAM_WDOG_EN` defined:
  - A counter of width clog2(WDOG_CYC+1) clears on every state change and increments in REF/WRITE/READ.
  - When it reaches WDOG_CYC, the FSM forces SW and sets `wdog_err`, which is sticky until `rst`.
- `SDRAM_WDOG_EN` undefined:
  - No counter is built; `wdog_err` is tied 0.

## Structure
- A shared package `sdram_pkg` holds:
  - The state one-hot localparams.
  - The NOP/command opcode constants `{cs_n,ras_n,cas_n,we_n}`.
  - The CMD_W derivation helper.
- Grant logic lives in one sub-module, `sdram_rr_grant`, which is the 2-way round-robin with refresh override. Its inputs are `ref_req`/`w_req`/`r_req`/`in_sw`; its outputs are the 3 grants and `last_wr` update.
- The FSM, command mux and tristate stay in the top module.

## Test plan
- Reset release with `init_end` rising at cycle 200 → IDLE→INI next cycle; SW at cycle 201. `cmd`=`init_cmd` only during INI.
- In SW, `ref_req`=`w_req`=`r_req`=1 → `ref_en` pulses 1 cycle and state=REF. After `ref_end`, a return to SW then `w_en` (last_wr=0 → write first).
- `w_req`=`r_req`=1 held continuously with `w_end`/`r_end` 4 cycles after each grant → grants alternate W,R,W,R. No `*_en` pulse overlaps another.
- In WRITE, `w_dq`=16'hA5A5 → `dq`=A5A5. In READ with the bench driving `dq`=16'h1234 → `r_dq`=1234 and no contention.
- `rst` asserted mid-WRITE → `state`=000001, `dq`=Z and `cmd`=NOP in the same cycle, before the next edge.
- `SDRAM_WDOG_EN` with WDOG_CYC=16, WRITE entered and `w_end` withheld → SW at cycle 16 and `wdog_err`=1 until `rst`. Without the macro, state stays WRITE indefinitely.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM main controller: one-hot state encodings,
// the command opcode used when no engine owns the bus, and the command-word
// width helper.
package sdram_pkg;

  localparam logic [5:0] ST_IDLE  = 6'b000001;
  localparam logic [5:0] ST_INI   = 6'b000010;
  localparam logic [5:0] ST_SW    = 6'b000100;
  localparam logic [5:0] ST_REF   = 6'b001000;
  localparam logic [5:0] ST_WRITE = 6'b010000;
  localparam logic [5:0] ST_READ  = 6'b100000;

  typedef enum logic [5:0] {
    S_IDLE  = ST_IDLE,
    S_INI   = ST_INI,
    S_SW    = ST_SW,
    S_REF   = ST_REF,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ
  } state_t;

  // {cs_n, ras_n, cas_n, we_n} for a NOP: chip selected, no strobe active
  localparam logic [3:0] OP_NOP = 4'b0111;

  // Command word is {cs_n,ras_n,cas_n,we_n,ba,addr}
  function automatic int cmd_width(input int ba_w, input int addr_w);
    return 4 + ba_w + addr_w;
  endfunction

endpackage

// File: rtl/sdram_rr_grant.sv
// Two-way round-robin between write and read engines with refresh override.
// Grants are combinational and only issued while the controller is in SW.
module sdram_rr_grant (
  input  logic clk,
  input  logic rst,
  input  logic ref_req,
  input  logic w_req,
  input  logic r_req,
  input  logic in_sw,
  output logic ref_gnt,
  output logic w_gnt,
  output logic r_gnt,
  output logic last_wr
);

  logic r_last_wr;

  // Refresh beats everything; contested write/read goes opposite to last winner
  always_comb begin
    ref_gnt = 1'b0;
    w_gnt   = 1'b0;
    r_gnt   = 1'b0;
    if (in_sw) begin
      if (ref_req) begin
        ref_gnt = 1'b1;
      end else if (w_req && r_req) begin
        if (r_last_wr) r_gnt = 1'b1;
        else           w_gnt = 1'b1;
      end else if (w_req) begin
        w_gnt = 1'b1;
      end else if (r_req) begin
        r_gnt = 1'b1;
      end
    end
  end

  // Remember whether the most recent data grant went to write; refresh leaves it alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_last_wr <= 1'b0;
    else if (w_gnt) r_last_wr <= 1'b1;
    else if (r_gnt) r_last_wr <= 1'b0;
  end

  assign last_wr = r_last_wr;

endmodule

// File: rtl/sdram_main_arb.sv
// SDRAM main controller/arbiter: sequences init, then hands the command bus
// to the refresh, write or read engine. Owns the command mux and DQ tristate.
// Optional watchdog on busy states is built when SDRAM_WDOG_EN is defined.
module sdram_main_arb
  import sdram_pkg::*;
#(
  parameter int DQ_W     = 16,
  parameter int BA_W     = 2,
  parameter int ADDR_W   = 12,
  parameter int CMD_W    = cmd_width(BA_W, ADDR_W),
  parameter int WDOG_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_end,
  input  logic [CMD_W-1:0] init_cmd,
  input  logic             ref_req,
  output logic             ref_en,
  input  logic             ref_end,
  input  logic [CMD_W-1:0] ref_cmd,
  input  logic             w_req,
  output logic             w_en,
  input  logic             w_end,
  input  logic             w_brk_end,
  input  logic [CMD_W-1:0] w_cmd,
  input  logic [DQ_W-1:0]  w_dq,
  input  logic             r_req,
  output logic             r_en,
  input  logic             r_end,
  input  logic             r_brk_end,
  input  logic [CMD_W-1:0] r_cmd,
  output logic [DQ_W-1:0]  r_dq,
  output logic [CMD_W-1:0] cmd,
  inout  wire  [DQ_W-1:0]  dq,
  output logic [5:0]       state,
  output logic             wdog_err
);

  state_t r_state;
  state_t w_state_next;
  logic   w_ref_gnt;
  logic   w_w_gnt;
  logic   w_r_gnt;
  logic   w_last_wr;
  logic   w_wdog_hit;

  sdram_rr_grant u_grant (
    .clk     (clk),
    .rst     (rst),
    .ref_req (ref_req),
    .w_req   (w_req),
    .r_req   (r_req),
    .in_sw   (r_state == S_SW),
    .ref_gnt (w_ref_gnt),
    .w_gnt   (w_w_gnt),
    .r_gnt   (w_r_gnt),
    .last_wr (w_last_wr)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: init sequencing, grant dispatch, end-pulse return, watchdog override
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_INI;
      S_INI:   if (init_end) w_state_next = S_SW;
      S_SW: begin
        if (w_ref_gnt)    w_state_next = S_REF;
        else if (w_w_gnt) w_state_next = S_WRITE;
        else if (w_r_gnt) w_state_next = S_READ;
      end
      S_REF:   if (ref_end) w_state_next = S_SW;
      S_WRITE: if (w_end || w_brk_end) w_state_next = S_SW;
      S_READ:  if (r_end || r_brk_end) w_state_next = S_SW;
      default: w_state_next = S_IDLE;
    endcase
    if (w_wdog_hit) w_state_next = S_SW;
  end

`ifdef SDRAM_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] r_wdog_cnt;
  logic              r_wdog_err;
  logic              w_busy;

  assign w_busy     = (r_state == S_REF) || (r_state == S_WRITE) || (r_state == S_READ);
  assign w_wdog_hit = w_busy && (r_wdog_cnt == WDOG_W'(WDOG_CYC));

  // Dwell counter restarts on every state change; error flag is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (w_state_next != r_state) r_wdog_cnt <= '0;
      else if (w_busy)             r_wdog_cnt <= r_wdog_cnt + 1'b1;
      if (w_wdog_hit)              r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_wdog_hit = 1'b0;
  // Watchdog not built: error flag is constant low, parameter kept referenced
  assign wdog_err   = 1'b0 & (WDOG_CYC > 0);
`endif

  // Command mux: the owning engine drives the bus, otherwise NOP
  always_comb begin
    cmd = {OP_NOP, {(CMD_W-4){1'b0}}};
    case (r_state)
      S_INI:   cmd = init_cmd;
      S_REF:   cmd = ref_cmd;
      S_WRITE: cmd = w_cmd;
      S_READ:  cmd = r_cmd;
      default: cmd = {OP_NOP, {(CMD_W-4){1'b0}}};
    endcase
  end

  assign ref_en = w_ref_gnt;
  assign w_en   = w_w_gnt;
  assign r_en   = w_r_gnt;
  assign state  = r_state;

  // DQ is driven only while writing; decoded straight from state so reset releases it at once
  assign dq   = (r_state == S_WRITE) ? w_dq : {DQ_W{1'bz}};
  assign r_dq = dq;

  // Round-robin history is internal to the grant block
  logic w_unused;
  assign w_unused = w_last_wr;

endmodule

// File: tb/tb_sdram_main_arb.sv
// Directed bench for sdram_main_arb: grant scoreboard, state/cmd/DQ checks.
module tb_sdram_main_arb;

  localparam int CMD_W = 18;
  localparam logic [CMD_W-1:0] NOP_CMD  = {4'b0111, 14'd0};
  localparam logic [CMD_W-1:0] INIT_CMD = 18'h0_2A5C;
  localparam logic [CMD_W-1:0] REF_CMD  = 18'h1_0041;
  localparam logic [CMD_W-1:0] WR_CMD   = 18'h3_1234;
  localparam logic [CMD_W-1:0] RD_CMD   = 18'h2_4321;
  localparam logic [5:0] S_IDLE = 6'b000001, S_INI = 6'b000010, S_SW = 6'b000100,
                         S_REF = 6'b001000, S_WR = 6'b010000, S_RD = 6'b100000;
  localparam logic [2:0] G_REF = 3'b100, G_W = 3'b010, G_R = 3'b001;

  logic clk = 1'b0;
  logic rst, init_end, ref_req, ref_end, w_req, w_end, w_brk_end, r_req, r_end, r_brk_end;
  logic ref_en, w_en, r_en, wdog_err;
  logic [15:0] w_dq, r_dq, tb_dq;
  logic tb_oe;
  logic [CMD_W-1:0] cmd;
  logic [5:0] state;
  wire  [15:0] dq;

  assign dq = tb_oe ? tb_dq : 16'bz;

  always #5 clk = ~clk;

  sdram_main_arb #(.DQ_W(16), .BA_W(2), .ADDR_W(12), .CMD_W(CMD_W), .WDOG_CYC(16)) dut (
    .clk(clk), .rst(rst), .init_end(init_end), .init_cmd(INIT_CMD),
    .ref_req(ref_req), .ref_en(ref_en), .ref_end(ref_end), .ref_cmd(REF_CMD),
    .w_req(w_req), .w_en(w_en), .w_end(w_end), .w_brk_end(w_brk_end), .w_cmd(WR_CMD), .w_dq(w_dq),
    .r_req(r_req), .r_en(r_en), .r_end(r_end), .r_brk_end(r_brk_end), .r_cmd(RD_CMD), .r_dq(r_dq),
    .cmd(cmd), .dq(dq), .state(state), .wdog_err(wdog_err)
  );

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: grants sampled at the falling edge against the scoreboard, then step past the rising edge
  task automatic cyc();
    logic [2:0] g;
    logic [2:0] e;
    @(negedge clk);
    g = {ref_en, w_en, r_en};
    if (g != 3'b000) begin
      chk("grant_onehot", {31'd0, $onehot(g)}, 32'd1);
      if (exp_q.size() == 0) begin
        chk("grant_unexpected", {29'd0, g}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("grant", {29'd0, g}, {29'd0, e});
        $display("grant ref/w/r=%b expected=%b t=%0t", g, e, $time);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; init_end = 1'b0; ref_req = 1'b0; ref_end = 1'b0;
    w_req = 1'b0; w_end = 1'b0; w_brk_end = 1'b0;
    r_req = 1'b0; r_end = 1'b0; r_brk_end = 1'b0;
    w_dq = 16'hA5A5; tb_dq = 16'h5A5A; tb_oe = 1'b1;

    // Reset state
    repeat (3) cyc();
    chk("rst_state", {26'd0, state}, {26'd0, S_IDLE});
    chk("rst_cmd", {14'd0, cmd}, {14'd0, NOP_CMD});
    chk("rst_en", {29'd0, ref_en, w_en, r_en}, 32'd0);
    chk("rst_wdog", {31'd0, wdog_err}, 32'd0);
    chk("rst_dq_released", {16'd0, r_dq}, {16'd0, 16'h5A5A});
    tb_oe = 1'b0;

    // Release reset: INI one cycle later, hold there until init_end
    rst = 1'b0;
    cyc();
    chk("ini_state", {26'd0, state}, {26'd0, S_INI});
    chk("ini_cmd", {14'd0, cmd}, {14'd0, INIT_CMD});
    repeat (198) cyc();
    chk("ini_hold", {26'd0, state}, {26'd0, S_INI});
    init_end = 1'b1;
    cyc();
    chk("sw_state", {26'd0, state}, {26'd0, S_SW});
    chk("sw_cmd", {14'd0, cmd}, {14'd0, NOP_CMD});

    // All three requests: refresh wins
    ref_req = 1'b1; w_req = 1'b1; r_req = 1'b1;
    exp_q.push_back(G_REF);
    cyc();
    chk("ref_state", {26'd0, state}, {26'd0, S_REF});
    chk("ref_cmd", {14'd0, cmd}, {14'd0, REF_CMD});
    ref_req = 1'b0;
    repeat (2) cyc();
    chk("ref_dwell", {26'd0, state}, {26'd0, S_REF});
    ref_end = 1'b1;
    cyc();
    ref_end = 1'b0;
    chk("ref_back_sw", {26'd0, state}, {26'd0, S_SW});
    exp_q.push_back(G_W);
    cyc();
    chk("first_contested_write", {26'd0, state}, {26'd0, S_WR});

    // Contested W/R: grants alternate W,R,W,R
    for (int k = 0; k < 3; k++) begin
      if (k % 2 == 0) begin
        #1 chk("wr_dq_drive", {16'd0, r_dq}, {16'd0, 16'hA5A5});
        chk("wr_cmd", {14'd0, cmd}, {14'd0, WR_CMD});
      end else begin
        tb_oe = 1'b1; tb_dq = 16'h1234;
        #1 chk("rd_dq_sample", {16'd0, r_dq}, {16'd0, 16'h1234});
        chk("rd_cmd", {14'd0, cmd}, {14'd0, RD_CMD});
      end
      repeat (2) cyc();
      if (k % 2 == 0) w_end = 1'b1; else r_end = 1'b1;
      tb_oe = 1'b0;
      cyc();
      w_end = 1'b0; r_end = 1'b0;
      chk("op_back_sw", {26'd0, state}, {26'd0, S_SW});
      exp_q.push_back((k % 2 == 0) ? G_R : G_W);
      cyc();
      chk("alt_state", {26'd0, state}, {26'd0, (k % 2 == 0) ? S_RD : S_WR});
    end

    // Leave READ with only a write pending
    r_req = 1'b0; r_end = 1'b1;
    cyc();
    r_end = 1'b0;
    exp_q.push_back(G_W);
    cyc();
    chk("write_again", {26'd0, state}, {26'd0, S_WR});

    // Asynchronous reset mid-WRITE: state, cmd and DQ respond before the next edge
    #2 rst = 1'b1; tb_oe = 1'b1; tb_dq = 16'h0FF0;
    #1;
    chk("async_rst_state", {26'd0, state}, {26'd0, S_IDLE});
    chk("async_rst_cmd", {14'd0, cmd}, {14'd0, NOP_CMD});
    chk("async_rst_dq", {16'd0, r_dq}, {16'd0, 16'h0FF0});
    repeat (2) cyc();
    tb_oe = 1'b0;
    rst = 1'b0;
    cyc();
    chk("reinit_ini", {26'd0, state}, {26'd0, S_INI});
    cyc();
    chk("reinit_sw", {26'd0, state}, {26'd0, S_SW});
    exp_q.push_back(G_W);
    cyc();
    w_req = 1'b0;
    chk("wdog_write", {26'd0, state}, {26'd0, S_WR});

    // Withhold w_end in WRITE
`ifdef SDRAM_WDOG_EN
    repeat (16) cyc();
    chk("wdog_pre", {26'd0, state}, {26'd0, S_WR});
    cyc();
    chk("wdog_forced_sw", {26'd0, state}, {26'd0, S_SW});
    chk("wdog_err_set", {31'd0, wdog_err}, 32'd1);
    repeat (5) cyc();
    chk("wdog_err_sticky", {31'd0, wdog_err}, 32'd1);
`else
    repeat (40) cyc();
    chk("no_wdog_state", {26'd0, state}, {26'd0, S_WR});
    chk("no_wdog_err", {31'd0, wdog_err}, 32'd0);
`endif
    rst = 1'b1;
    cyc();
    chk("final_rst_wdog", {31'd0, wdog_err}, 32'd0);
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
